// File: rtl/rk05_bus_receiver_if.sv
// Controller-side bus and internal seek handshake for the RK05 cylinder-address receiver.
// The master drives the raw pads and the handshake inputs; the slave is the receiver itself.
interface rk05_bus_receiver_if;
  logic [7:0] bus_cyl_addr_n;
  logic       bus_strobe_n;
  logic       bus_restore_n;
  logic       seek_ack;
  logic       overrun_clr;
  logic       seek_req;
  logic [7:0] seek_cyl;
  logic       seek_restore;
  logic       busy;
  logic       overrun;

  modport master (
    output bus_cyl_addr_n, bus_strobe_n, bus_restore_n, seek_ack, overrun_clr,
    input  seek_req, seek_cyl, seek_restore, busy, overrun
  );

  modport slave (
    input  bus_cyl_addr_n, bus_strobe_n, bus_restore_n, seek_ack, overrun_clr,
    output seek_req, seek_cyl, seek_restore, busy, overrun
  );
endinterface

// File: rtl/rk05_bus_receiver.sv
// RK05 cylinder-address receiver: synchronizes the raw pads, filters the strobe and hands one
// captured seek command at a time to the internal seek logic.
module rk05_bus_receiver #(
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  rk05_bus_receiver_if.slave bus
);

  localparam logic [3:0] FILTER_LAST = 4'(FILTER_CYCLES - 1);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PENDING      = 2'd1;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;

  logic [9:0] raw_in;
  logic [9:0] sync_meta_q, sync_meta_d;
  logic [9:0] sync_q, sync_d;
  logic       strobe_sync;
  logic       restore_sync;
  logic [7:0] addr_sync;

  logic [3:0] filt_cnt_q, filt_cnt_d;
  logic       qual_q, qual_d;

  logic [1:0] state_q, state_d;
  logic [7:0] seek_cyl_q, seek_cyl_d;
  logic       seek_restore_q, seek_restore_d;
  logic       released_q, released_d;
  logic       overrun_q, overrun_d;
  logic       overrun_set;

  assign raw_in       = {bus.bus_restore_n, bus.bus_strobe_n, bus.bus_cyl_addr_n};
  assign strobe_sync  = ~sync_q[8];
  assign restore_sync = ~sync_q[9];
  assign addr_sync    = ~sync_q[7:0];

  always_comb begin
    sync_meta_d = raw_in;
    sync_d      = sync_meta_q;
  end

  // A level change only counts once it has persisted FILTER_CYCLES synchronized samples.
  always_comb begin
    filt_cnt_d = 4'd0;
    qual_d     = qual_q;
    if (strobe_sync != qual_q) begin
      if (filt_cnt_q == FILTER_LAST) begin
        qual_d = ~qual_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    seek_cyl_d     = seek_cyl_q;
    seek_restore_d = seek_restore_q;
    released_d     = released_q;
    overrun_set    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        released_d = 1'b0;
        if (qual_q) begin
          state_d        = ST_PENDING;
          seek_cyl_d     = addr_sync;
          seek_restore_d = restore_sync;
        end
      end
      ST_PENDING: begin
        // released_q remembers a release so a later re-assertion is seen as a dropped strobe.
        if (!qual_q) begin
          released_d = 1'b1;
        end else if (released_q) begin
          overrun_set = 1'b1;
          released_d  = 1'b0;
        end
        if (bus.seek_ack) begin
          state_d    = qual_q ? ST_WAIT_RELEASE : ST_IDLE;
          released_d = 1'b0;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!qual_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    overrun_d = overrun_set | (overrun_q & ~bus.overrun_clr);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta_q    <= '1;
      sync_q         <= '1;
      filt_cnt_q     <= 4'd0;
      qual_q         <= 1'b0;
      state_q        <= ST_IDLE;
      seek_cyl_q     <= 8'd0;
      seek_restore_q <= 1'b0;
      released_q     <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      sync_meta_q    <= sync_meta_d;
      sync_q         <= sync_d;
      filt_cnt_q     <= filt_cnt_d;
      qual_q         <= qual_d;
      state_q        <= state_d;
      seek_cyl_q     <= seek_cyl_d;
      seek_restore_q <= seek_restore_d;
      released_q     <= released_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.seek_req     = (state_q == ST_PENDING);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.seek_cyl     = seek_cyl_q;
  assign bus.seek_restore = seek_restore_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_rk05_bus_receiver.sv
// Directed bench for rk05_bus_receiver with FILTER_CYCLES=4; E0 is the first edge sampling strobe low.
module tb_rk05_bus_receiver;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  rk05_bus_receiver_if bif ();

  rk05_bus_receiver #(.FILTER_CYCLES(4)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] addr_n, input logic strobe_n, input logic restore_n);
    bif.bus_cyl_addr_n = addr_n;
    bif.bus_strobe_n   = strobe_n;
    bif.bus_restore_n  = restore_n;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bif.busy !== 1'b0 && n < 30) begin
      tick(1);
      n++;
    end
    checks++;
    if (bif.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_idle: busy=%b required 0 within 30 cycles", name, bif.busy);
    end
    tick(3);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    drive(8'hFF, 1'b1, 1'b1);
    bif.seek_ack    = 1'b0;
    bif.overrun_clr = 1'b0;
    #3;
    checks++;
    if ({bif.seek_req, bif.busy, bif.overrun, bif.seek_restore, bif.seek_cyl} !== 12'h000) begin
      failures++;
      $display("[TB] FAIL reset_outputs: req=%b busy=%b ovr=%b rst=%b cyl=%h required all 0",
               bif.seek_req, bif.busy, bif.overrun, bif.seek_restore, bif.seek_cyl);
    end
    tick(3);
    reset_n = 1'b1;
    tick(5);
    checks++;
    if (bif.busy !== 1'b0 || bif.seek_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle: busy=%b req=%b required 0 0", bif.busy, bif.seek_req);
    end
  endtask

  task automatic test_basic;
    drive(8'hB6, 1'b0, 1'b1);
    tick(6);
    checks++;
    if (bif.seek_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_req_early: seek_req=%b at E5 required 0", bif.seek_req);
    end
    tick(1);
    checks++;
    if (bif.seek_req !== 1'b1 || bif.seek_cyl !== 8'h49 || bif.seek_restore !== 1'b0 || bif.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_capture: req=%b cyl=%h rst=%b busy=%b required 1 49 0 1",
               bif.seek_req, bif.seek_cyl, bif.seek_restore, bif.busy);
    end
    bif.seek_ack = 1'b1;
    tick(1);
    bif.seek_ack = 1'b0;
    checks++;
    if (bif.seek_req !== 1'b0 || bif.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_ack: req=%b busy=%b required 0 1", bif.seek_req, bif.busy);
    end
    tick(2);
    drive(8'hB6, 1'b1, 1'b1);
    tick(6);
    checks++;
    if (bif.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_release_early: busy=%b at E15 required 1", bif.busy);
    end
    tick(1);
    checks++;
    if (bif.busy !== 1'b0 || bif.seek_cyl !== 8'h49) begin
      failures++;
      $display("[TB] FAIL basic_release: busy=%b cyl=%h at E16 required 0 49", bif.busy, bif.seek_cyl);
    end
    tick(3);
  endtask

  task automatic test_short_pulse;
    logic seen;
    seen = 1'b0;
    drive(8'h00, 1'b0, 1'b1);
    tick(3);
    drive(8'h00, 1'b1, 1'b1);
    bif.seek_ack = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (bif.seek_req !== 1'b0 || bif.busy !== 1'b0) seen = 1'b1;
    end
    bif.seek_ack = 1'b0;
    checks++;
    if (seen !== 1'b0 || bif.seek_cyl !== 8'h49) begin
      failures++;
      $display("[TB] FAIL short_pulse: activity=%b cyl=%h required 0 49", seen, bif.seek_cyl);
    end
    tick(2);
  endtask

  task automatic test_min_pulse;
    drive(8'hA5, 1'b0, 1'b1);
    tick(4);
    drive(8'hA5, 1'b1, 1'b1);
    tick(2);
    checks++;
    if (bif.seek_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL min_pulse_early: seek_req=%b at E5 required 0", bif.seek_req);
    end
    tick(1);
    checks++;
    if (bif.seek_req !== 1'b1 || bif.seek_cyl !== 8'h5A) begin
      failures++;
      $display("[TB] FAIL min_pulse_capture: req=%b cyl=%h required 1 5a", bif.seek_req, bif.seek_cyl);
    end
    tick(6);
    bif.seek_ack = 1'b1;
    tick(1);
    bif.seek_ack = 1'b0;
    checks++;
    if (bif.seek_req !== 1'b0 || bif.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL min_pulse_ack_idle: req=%b busy=%b required 0 0", bif.seek_req, bif.busy);
    end
    tick(3);
  endtask

  task automatic test_wait_release;
    logic seen;
    seen = 1'b0;
    drive(8'hCC, 1'b0, 1'b1);
    tick(7);
    checks++;
    if (bif.seek_req !== 1'b1 || bif.seek_cyl !== 8'h33) begin
      failures++;
      $display("[TB] FAIL wait_capture: req=%b cyl=%h required 1 33", bif.seek_req, bif.seek_cyl);
    end
    bif.seek_ack = 1'b1;
    tick(1);
    bif.seek_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bif.seek_req !== 1'b0) seen = 1'b1;
    end
    drive(8'hCC, 1'b1, 1'b1);
    tick(2);
    drive(8'hCC, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bif.seek_req !== 1'b0 || bif.busy !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || bif.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wait_hold: extra_req_or_drop=%b busy=%b required 0 1", seen, bif.busy);
    end
    drive(8'hCC, 1'b1, 1'b1);
    wait_idle("wait_release");
  endtask

  task automatic test_overrun;
    drive(8'hEF, 1'b0, 1'b1);
    tick(6);
    drive(8'hEF, 1'b1, 1'b1);
    tick(1);
    checks++;
    if (bif.seek_req !== 1'b1 || bif.seek_cyl !== 8'h10) begin
      failures++;
      $display("[TB] FAIL overrun_first: req=%b cyl=%h required 1 10", bif.seek_req, bif.seek_cyl);
    end
    drive(8'hDF, 1'b1, 1'b1);
    tick(7);
    drive(8'hDF, 1'b0, 1'b1);
    tick(6);
    checks++;
    if (bif.overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overrun_early: overrun=%b required 0", bif.overrun);
    end
    bif.overrun_clr = 1'b1;
    tick(1);
    checks++;
    if (bif.overrun !== 1'b1 || bif.seek_cyl !== 8'h10 || bif.seek_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overrun_set: ovr=%b cyl=%h req=%b required 1 10 1",
               bif.overrun, bif.seek_cyl, bif.seek_req);
    end
    tick(1);
    bif.overrun_clr = 1'b0;
    checks++;
    if (bif.overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overrun_clear: overrun=%b required 0", bif.overrun);
    end
    bif.seek_ack = 1'b1;
    tick(1);
    bif.seek_ack = 1'b0;
    checks++;
    if (bif.seek_req !== 1'b0 || bif.busy !== 1'b1 || bif.seek_cyl !== 8'h10) begin
      failures++;
      $display("[TB] FAIL overrun_ack: req=%b busy=%b cyl=%h required 0 1 10",
               bif.seek_req, bif.busy, bif.seek_cyl);
    end
    drive(8'hDF, 1'b1, 1'b1);
    wait_idle("overrun");
  endtask

  task automatic test_restore;
    drive(8'hFF, 1'b0, 1'b0);
    tick(7);
    checks++;
    if (bif.seek_req !== 1'b1 || bif.seek_restore !== 1'b1 || bif.seek_cyl !== 8'h00) begin
      failures++;
      $display("[TB] FAIL restore_capture: req=%b rst=%b cyl=%h required 1 1 00",
               bif.seek_req, bif.seek_restore, bif.seek_cyl);
    end
    bif.seek_ack = 1'b1;
    tick(1);
    bif.seek_ack = 1'b0;
    drive(8'hFF, 1'b1, 1'b1);
    wait_idle("restore");
  endtask

  task automatic test_reset_mid;
    logic seen;
    seen = 1'b0;
    drive(8'h88, 1'b0, 1'b0);
    tick(7);
    checks++;
    if (bif.seek_req !== 1'b1 || bif.seek_cyl !== 8'h77 || bif.seek_restore !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mid_capture: req=%b cyl=%h rst=%b required 1 77 1",
               bif.seek_req, bif.seek_cyl, bif.seek_restore);
    end
    #2;
    reset_n = 1'b0;
    drive(8'h88, 1'b1, 1'b1);
    #1;
    checks++;
    if ({bif.seek_req, bif.busy, bif.overrun, bif.seek_restore, bif.seek_cyl} !== 12'h000) begin
      failures++;
      $display("[TB] FAIL reset_mid_async: req=%b busy=%b ovr=%b rst=%b cyl=%h required all 0",
               bif.seek_req, bif.busy, bif.overrun, bif.seek_restore, bif.seek_cyl);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (bif.seek_req !== 1'b0 || bif.busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_no_req: activity=%b required 0", seen);
    end
  endtask

  task automatic test_reset_held_strobe;
    reset_n = 1'b0;
    drive(8'hC3, 1'b0, 1'b1);
    tick(2);
    reset_n = 1'b1;
    tick(6);
    checks++;
    if (bif.seek_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL held_strobe_early: seek_req=%b at E5 required 0", bif.seek_req);
    end
    tick(1);
    checks++;
    if (bif.seek_req !== 1'b1 || bif.seek_cyl !== 8'h3C) begin
      failures++;
      $display("[TB] FAIL held_strobe_capture: req=%b cyl=%h required 1 3c", bif.seek_req, bif.seek_cyl);
    end
    bif.seek_ack = 1'b1;
    tick(1);
    bif.seek_ack = 1'b0;
    drive(8'hC3, 1'b1, 1'b1);
    wait_idle("held_strobe");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_short_pulse();
    test_min_pulse();
    test_wait_release();
    test_overrun();
    test_restore();
    test_reset_mid();
    test_reset_held_strobe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rk05_bus_receiver.md
RK05_BUS_RECEIVER -- requirements
Module: rk05_bus_receiver

Interface
REQ-001 Parameter FILTER_CYCLES, default 4: consecutive synchronized cycles needed to qualify a strobe edge; legal range 1..15.
REQ-002 clock  input  1  single system clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 bus_cyl_addr_n  input  8  raw cylinder address from controller input pads, active-low.
REQ-005 bus_strobe_n  input  1  raw cylinder address strobe from input pad, active-low.
REQ-006 bus_restore_n  input  1  raw restore request from input pad, active-low; sampled with strobe.
REQ-007 seek_ack  input  1  internal seek logic accepted the pending command.
REQ-008 overrun_clr  input  1  clears sticky overrun flag.
REQ-009 seek_req  output  1  command pending toward internal seek logic.
REQ-010 seek_cyl  output  8  captured cylinder address, active-high.
REQ-011 seek_restore  output  1  captured restore flag, active-high.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 overrun  output  1  sticky: a strobe was dropped while a command was pending.

Function
REQ-014 Block SHALL pass all ten bus inputs through a two-flop synchronizer before any other use.
- Edge E0 is the first rising edge sampling raw strobe low.
REQ-015 Strobe filter SHALL use a 4-bit counter: increment while synchronized strobe differs from the qualified level, clear otherwise; qualified level toggles and counter clears when the count reaches FILTER_CYCLES.
REQ-016 Raw strobe pulses, or gaps in a held strobe, shorter than FILTER_CYCLES cycles SHALL NOT change the qualified level.
REQ-017 The FSM SHALL have states IDLE, PENDING and WAIT_RELEASE.
REQ-018 IDLE -> PENDING on qualified strobe assertion: latch inverted synchronized address into seek_cyl and restore into seek_restore, and set seek_req; seek_req is high after edge E(FILTER_CYCLES+2).
REQ-019 PENDING: seek_req, seek_cyl and seek_restore SHALL stay stable until seek_ack is sampled high; seek_req falls on that edge.
REQ-020 On ack, the next state SHALL be WAIT_RELEASE if the qualified strobe is still asserted, otherwise IDLE.
REQ-021 WAIT_RELEASE -> IDLE on qualified strobe deassertion; no new capture occurs before return to IDLE.
REQ-022 In PENDING, a qualified deassertion followed by a new qualified assertion before ack SHALL set overrun; the new address is discarded and seek_cyl is unchanged.
REQ-023 seek_ack while seek_req is low SHALL be ignored.
REQ-024 seek_cyl and seek_restore SHALL hold their last captured values in IDLE and WAIT_RELEASE.
REQ-025 overrun_clr SHALL clear overrun on the next edge; a simultaneous set takes priority over the clear.
REQ-026 Every qualified assertion SHALL produce at most one seek_req.

Reset
REQ-027 reset_n low SHALL immediately force: FSM to IDLE, seek_req=0, seek_cyl=0, seek_restore=0, busy=0, overrun=0, filter counter=0, qualified strobe deasserted, synchronizer flops to the deasserted (high) level.
REQ-028 Reset mid-command SHALL discard the pending command with no seek_req after release.
REQ-029 After release, a strobe already held low SHALL be treated as a new assertion and captured after the normal filter latency.

Verification
REQ-030 FILTER_CYCLES=4; addr_n=8'hB6 (cyl 0x49), strobe_n low for 10 cycles, restore_n high -> seek_req high after E6; seek_cyl=0x49, seek_restore=0; ack at next edge -> seek_req low, busy low after release.
REQ-031 Strobe_n low for 3 cycles, then high -> no seek_req and busy stays 0.
REQ-032 Strobe held low; ack given -> WAIT_RELEASE, busy=1, no second request; strobe high for 4+ cycles -> IDLE.
REQ-033 Capture cyl 0x10 with no ack; release, then strobe cyl 0x20 -> overrun=1, seek_cyl remains 0x10; overrun_clr -> overrun=0.
REQ-034 reset_n low while PENDING -> all outputs 0 immediately; reset released with strobe high -> no request.
REQ-035 restore_n low with strobe, addr 8'hFF -> seek_restore=1, seek_cyl=0x00.
